inst_prefetch_queue: RTL and testbench

- Fetch stage between instruction memory and the instruction decoder.
- Issues sequential 32-bit instruction fetch requests over a valid/ready request channel and accepts in-order responses.
- Buffers fetched words with their PCs in a FIFO and presents the head word to decode with a valid/ready handshake.
- On a control-flow redirect, flushes all buffered and in-flight fetches and restarts at the new PC.

---
 rtl/inst_prefetch_queue_if.sv | 44 ++++
 rtl/inst_prefetch_queue.sv | 172 +++++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_queue_if.sv
// Fetch-stage bus: the memory request/response channel, the redirect
// request and the decode-side instruction handshake.
// master: the prefetch queue.  slave: memory plus decoder side.
interface inst_prefetch_queue_if;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        inst_ready;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  redirect,
    input  redirect_pc,
    output inst_valid,
    output inst_word,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output redirect,
    output redirect_pc,
    input  inst_valid,
    input  inst_word,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential 32-bit fetches, buffers the
// returned words with their PCs, and hands them to decode in order.
// A redirect flushes the queue and discards responses still in flight.
// Optional statistics counters are enabled with INST_PREFETCH_STATS_EN.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000,
  parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_prefetch_queue_if.master bus,
  output logic [CNT_W-1:0]      occupancy
`ifdef INST_PREFETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [31:0]           stat_discarded,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] pending;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [31:0] word_mem [DEPTH];
  logic [63:0] pc_mem   [DEPTH];

  logic           req_fire;
  logic           push;
  logic           pop;
  logic [CNT_W:0] credit_used;

  // Credits cover both buffered entries and requests still in flight, so
  // every accepted request is guaranteed a free slot when it returns.
  always_comb begin
    credit_used       = {1'b0, occ_q} + {1'b0, outst_q};
    bus.mem_req_valid = !rst && (state_q == StRun) && !bus.redirect &&
                        (credit_used < DEPTH_W);
    bus.mem_req_addr  = fetch_pc_q;
    req_fire          = bus.mem_req_valid && bus.mem_req_ready;
    bus.inst_valid    = !rst && (occ_q != '0);
    bus.inst_word     = bus.inst_valid ? word_mem[head_q] : '0;
    bus.inst_pc       = bus.inst_valid ? pc_mem[head_q] : '0;
    occupancy         = occ_q;
    // A response without a matching outstanding request is ignored.
    push              = !bus.redirect && (state_q == StRun) && bus.mem_rsp_valid &&
                        (outst_q != '0);
    pop               = !bus.redirect && bus.inst_valid && bus.inst_ready;
  end

  // Next-state: normal fetch/fill/drain, then redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    occ_d      = occ_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pending    = discard_q + outst_q;

    unique case (state_q)
      StRun: begin
        if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
        if (push) begin
          tail_d   = tail_q + PTR_W'(1);
          rsp_pc_d = rsp_pc_q + 64'd4;
        end
        outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(push);
      end
      StFlush: begin
        if (bus.mem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        if (discard_d == '0) state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) head_d = head_q + PTR_W'(1);

    if (bus.redirect) begin
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
      outst_d    = '0;
      // Everything in flight becomes stale; a response arriving now is one
      // of them and is dropped immediately.
      discard_d  = (bus.mem_rsp_valid && (pending != '0)) ? pending - CNT_W'(1) : pending;
      state_d    = (discard_d != '0) ? StFlush : StRun;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage: written at the tail on every accepted response.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      word_mem[tail_q] <= bus.mem_rsp_data;
      pc_mem[tail_q]   <= rsp_pc_q;
    end
  end

`ifdef INST_PREFETCH_STATS_EN
  logic rsp_drop;

  // Responses thrown away either in the redirect cycle or while flushing.
  always_comb begin
    rsp_drop = 1'b0;
    if (bus.mem_rsp_valid) begin
      if (bus.redirect) rsp_drop = (pending != '0);
      else              rsp_drop = (state_q == StFlush) && (discard_q != '0);
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched      <= '0;
      stat_discarded    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (req_fire && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
      if (rsp_drop && (stat_discarded != '1)) stat_discarded <= stat_discarded + 32'd1;
      if ((state_q == StRun) && !bus.inst_valid && bus.inst_ready &&
          (stat_stall_cycles != '1)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

  // A response nobody asked for is a memory-side protocol violation.
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_rsp_valid && (outst_q == '0) && (discard_q == '0)));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with an in-order, variable-latency
// memory model driven from the stimulus thread.
module tb_inst_prefetch_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] occupancy;
`ifdef INST_PREFETCH_STATS_EN
  logic [31:0] stat_fetched, stat_discarded, stat_stall_cycles;
`endif

  inst_prefetch_queue_if ifc ();

  inst_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (64'h2000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .occupancy (occupancy)
`ifdef INST_PREFETCH_STATS_EN
    ,
    .stat_fetched      (stat_fetched),
    .stat_discarded    (stat_discarded),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_fired = 0;
  logic [63:0] pend_addr [$];
  int          pend_due  [$];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return ~a[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: note a request at negedge, update the memory after the edge,
  // then present the next due response.
  task automatic tick();
    logic        fire;
    logic [63:0] a;
    @(negedge clk);
    fire = ifc.mem_req_valid && ifc.mem_req_ready;
    a    = ifc.mem_req_addr;
    @(posedge clk);
    if (ifc.mem_rsp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (fire) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + lat);
      n_fired++;
    end
    cyc++;
    #1;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      ifc.mem_rsp_valid = 1'b1;
      ifc.mem_rsp_data  = word_of(pend_addr[0]);
    end else begin
      ifc.mem_rsp_valid = 1'b0;
      ifc.mem_rsp_data  = '0;
    end
  endtask

  task automatic drain();
    ifc.mem_req_ready = 1'b0;
    ifc.inst_ready    = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    int w;
    rst               = 1'b1;
    ifc.mem_req_ready = 1'b1;
    ifc.mem_rsp_valid = 1'b0;
    ifc.mem_rsp_data  = '0;
    ifc.redirect      = 1'b0;
    ifc.redirect_pc   = '0;
    ifc.inst_ready    = 1'b1;
    #2;
    check("reset_req_valid", ifc.mem_req_valid, 0);
    check("reset_inst_valid", ifc.inst_valid, 0);
    tick();
    tick();
    check("reset_occupancy", occupancy, 0);
    check("reset_inst_word", ifc.inst_word, 0);
    check("reset_inst_pc", ifc.inst_pc, 0);
    rst = 1'b0;
    #1;
    check("first_req_valid", ifc.mem_req_valid, 1);
    check("first_req_addr", ifc.mem_req_addr, 64'h2000);

    // Streaming with a 1-cycle memory and an always-ready decoder.
    tick();
    check("no_bypass", ifc.inst_valid, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stream_valid", ifc.inst_valid, 1);
      check("stream_pc", ifc.inst_pc, 64'h2000 + 64'(4 * k));
      check("stream_word", ifc.inst_word, word_of(64'h2000 + 64'(4 * k)));
      check("stream_occ", occupancy, 1);
      tick();
    end

    // Stalled decoder: the queue fills by credits and stops fetching.
    drain();
    rst = 1'b1;
    tick();
    rst               = 1'b0;
    ifc.mem_req_ready = 1'b1;
    ifc.inst_ready    = 1'b0;
    n_fired           = 0;
    repeat (8) tick();
    check("full_fired", n_fired, 4);
    check("full_occ", occupancy, 4);
    check("full_req_valid", ifc.mem_req_valid, 0);
    check("full_head_pc", ifc.inst_pc, 64'h2000);
    ifc.inst_ready = 1'b1;
    n_fired        = 0;
    tick();
    ifc.inst_ready = 1'b0;
    repeat (4) tick();
    check("refill_fired", n_fired, 1);
    check("refill_occ", occupancy, 4);
    check("refill_head_pc", ifc.inst_pc, 64'h2004);

    // 3-cycle memory, redirect with two requests outstanding.
    drain();
    lat               = 3;
    ifc.mem_req_ready = 1'b1;
    tick();
    tick();
    ifc.mem_req_ready = 1'b0;
    ifc.redirect      = 1'b1;
    ifc.redirect_pc   = 64'h3000;
    tick();
    ifc.redirect      = 1'b0;
    ifc.mem_req_ready = 1'b1;
    check("flush_occ", occupancy, 0);
    check("flush_inst_valid", ifc.inst_valid, 0);
    check("flush_discard", dut.discard_q, 2);
    check("flush_req_blocked1", ifc.mem_req_valid, 0);
    tick();
    check("flush_req_blocked2", ifc.mem_req_valid, 0);
    tick();
    check("restart_req_valid", ifc.mem_req_valid, 1);
    check("restart_req_addr", ifc.mem_req_addr, 64'h3000);
    w = 0;
    while (!ifc.inst_valid && w < 10) begin
      tick();
      w++;
    end
    check("restart_wait", ifc.inst_valid, 1);
    check("restart_pc", ifc.inst_pc, 64'h3000);
    check("restart_word", ifc.inst_word, word_of(64'h3000));

    // Redirect in the same cycle as a response and a pop; target wraps.
    drain();
    lat               = 3;
    ifc.inst_ready    = 1'b0;
    ifc.mem_req_ready = 1'b1;
    repeat (3) tick();
    ifc.mem_req_ready = 1'b0;
    tick();
    check("pre_redirect_occ", occupancy, 1);
    check("pre_redirect_rsp", ifc.mem_rsp_valid, 1);
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    ifc.inst_ready  = 1'b1;
    tick();
    ifc.redirect   = 1'b0;
    ifc.inst_ready = 1'b0;
    check("coinc_occ", occupancy, 0);
    check("coinc_inst_valid", ifc.inst_valid, 0);
    check("coinc_discard", dut.discard_q, 1);
    check("coinc_req_blocked", ifc.mem_req_valid, 0);
    tick();
    check("wrap_req_valid", ifc.mem_req_valid, 1);
    check("wrap_req_addr", ifc.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    ifc.mem_req_ready = 1'b1;
    tick();
    ifc.mem_req_ready = 1'b0;
    check("wrap_next_addr", ifc.mem_req_addr, 64'h0);
    repeat (5) tick();
    check("wrap_occ", occupancy, 1);
    check("wrap_head_pc", ifc.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_head_word", ifc.inst_word, 32'h3);

`ifdef INST_PREFETCH_STATS_EN
    // Five fetches, the last two still in flight at the redirect.
    drain();
    rst = 1'b1;
    tick();
    rst               = 1'b0;
    lat               = 1;
    ifc.inst_ready    = 1'b1;
    ifc.mem_req_ready = 1'b1;
    repeat (3) tick();
    lat = 3;
    repeat (2) tick();
    ifc.mem_req_ready = 1'b0;
    ifc.redirect      = 1'b1;
    ifc.redirect_pc   = 64'h4000;
    tick();
    ifc.redirect = 1'b0;
    check("stat_fetched_at_redirect", stat_fetched, 5);
    tick();
    tick();
    check("stat_discarded", stat_discarded, 2);
    lat               = 1;
    ifc.mem_req_ready = 1'b1;
    tick();
    tick();
    check("stat_fetched_after", stat_fetched, 7);
    check("stat_discarded_after", stat_discarded, 2);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
